// File: rtl/f16_fmac_dot_seq.sv
// f16_fmac_dot_seq
// Sequences an FP16 dot product (sum of x[i]*y[i], plus z_init) through an
// external combinational FMAC. Operand pairs are registered onto the FMAC
// x/y ports. The accumulator drives the FMAC z port. Each FMAC result is
// folded back into the accumulator. The block itself does no arithmetic on
// the FP16 words.
//
// Handshake rule for both streams: a transfer happens on the rising edge
// where valid and ready are both high. Ready and valid are decoded from the
// state register only, so neither one depends combinationally on its partner.
module f16_fmac_dot_seq #(
  parameter int LEN_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [15:0]      z_init_i,
  input  logic             abort_i,
  output logic             busy_o,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [15:0]      in_x_i,
  input  logic [15:0]      in_y_i,
  output logic [15:0]      fmac_x_o,
  output logic [15:0]      fmac_y_o,
  output logic [15:0]      fmac_z_o,
  input  logic [15:0]      fmac_result_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [15:0]      out_data_o,
  output logic [LEN_W-1:0] out_count_o,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ACC   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      acc_q, acc_d;
  logic [15:0]      x_q, x_d;
  logic [15:0]      y_q, y_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;

  // State and datapath registers; async reset discards any partial job.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath update. Abort overrides everything and freezes
  // the accumulator and count so the last partial values stay observable.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    x_d     = x_q;
    y_d     = y_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            acc_d = z_init_i;
            cnt_d = '0;
            if (len_i != '0) begin
              rem_d   = len_i;
              state_d = S_FETCH;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_FETCH: begin
          if (in_valid_i) begin
            x_d     = in_x_i;
            y_d     = in_y_i;
            state_d = S_ACC;
          end
        end
        S_ACC: begin
          // The FMAC settles on the registered operands during this cycle.
          acc_d   = fmac_result_i;
          rem_d   = rem_q - LEN_W'(1);
          cnt_d   = cnt_q + LEN_W'(1);
          state_d = (rem_q == LEN_W'(1)) ? S_DONE : S_FETCH;
        end
        S_DONE: begin
          if (out_ready_i) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign in_ready_o  = (state_q == S_FETCH);
  assign out_valid_o = (state_q == S_DONE);
  assign fmac_x_o    = x_q;
  assign fmac_y_o    = y_q;
  assign fmac_z_o    = acc_q;
  assign out_data_o  = acc_q;
  assign out_count_o = cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_f16_fmac_dot_seq.sv
// Bench for f16_fmac_dot_seq. A behavioural FP16 FMA stub sits on the fmac_*
// ports. Expected sums come from folding fma(x, y, acc) over each job's pairs.
module tb_f16_fmac_dot_seq;

  localparam int LEN_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic [15:0]      z_init = '0;
  logic             abort = 1'b0;
  logic             busy;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      in_x = '0;
  logic [15:0]      in_y = '0;
  logic [15:0]      fmac_x, fmac_y, fmac_z, fmac_result;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [15:0]      out_data;
  logic [LEN_W-1:0] out_count;
  logic [1:0]       dbg_state;

  f16_fmac_dot_seq #(.LEN_W(LEN_W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len), .z_init_i(z_init),
    .abort_i(abort), .busy_o(busy), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_x_i(in_x), .in_y_i(in_y), .fmac_x_o(fmac_x), .fmac_y_o(fmac_y),
    .fmac_z_o(fmac_z), .fmac_result_i(fmac_result), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_data_o(out_data), .out_count_o(out_count),
    .dbg_state_o(dbg_state)
  );

  // ---------------- FP16 reference arithmetic ----------------
  function automatic real h2r(input logic [15:0] h);
    real v;
    int  e;
    e = int'(h[14:10]);
    if (e == 0) v = real'(h[9:0]) * (2.0 ** (-24));
    else        v = real'(1024 + int'(h[9:0])) * (2.0 ** (e - 25));
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    logic [63:0] b, q, rem, half, mant;
    logic        s;
    int          e, sh;
    b = $realtobits(r);
    s = b[63];
    if (b[62:0] == 63'd0) return {s, 15'd0};
    e = int'(b[62:52]) - 1023;
    mant = {11'd0, 1'b1, b[51:0]};
    if (e > 15) return {s, 15'h7C00};
    sh = (e >= -14) ? 42 : 28 - e;
    if (sh >= 54) return {s, 15'd0};
    q    = mant >> sh;
    rem  = mant & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 64'd1;
    if (e >= -14) begin
      if (q == 64'd2048) begin
        q = 64'd1024;
        e = e + 1;
      end
      if (e > 15) return {s, 15'h7C00};
      return {s, 5'(e + 15), q[9:0]};
    end
    return {s, q[14:0]};
  endfunction

  function automatic logic [15:0] fma16(input logic [15:0] x, y, z);
    return r2h(h2r(x) * h2r(y) + h2r(z));
  endfunction

  // The external FMAC stand-in.
  assign fmac_result = fma16(fmac_x, fmac_y, fmac_z);

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];
  logic [LEN_W-1:0] cnt_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks (all begin and end at a negedge) ----------------
  logic [15:0] job_x[256];
  logic [15:0] job_y[256];

  task automatic start_job(input logic [LEN_W-1:0] l, input logic [15:0] z);
    start = 1'b1; len = l; z_init = z;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed_pairs(input int n, input int gap_max);
    int cyc;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1; in_x = job_x[i]; in_y = job_y[i];
      cyc = 0;
      while (!in_ready && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      if (cyc >= 100) chk("in_ready_timeout", 0, 1);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic get_result(input int hold_max, output logic [15:0] d,
                            output logic [LEN_W-1:0] c);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 200) chk("out_valid_timeout", 0, 1);
    repeat ($urandom_range(0, hold_max)) @(negedge clk);
    d = out_data; c = out_count;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("busy_after_out", 32'(busy), 0);
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic [LEN_W-1:0] l;
    logic [15:0]      z;
    logic [15:0]      x[4];
    logic [15:0]      y[4];
    logic [15:0]      exp_d;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [15:0]      d;
    logic [LEN_W-1:0] c;
    logic [15:0]      acc;
    int               n;

    vecs[0] = '{8'd2, 16'h0000, '{16'h3C00, 16'h4000, 0, 0}, '{16'h4000, 16'h4200, 0, 0}, 16'h4800};
    vecs[1] = '{8'd3, 16'h3C00, '{16'h3C00, 16'h3C00, 16'h3C00, 0}, '{16'h3C00, 16'h3C00, 16'h3C00, 0}, 16'h4400};
    vecs[2] = '{8'd1, 16'h0000, '{16'h4000, 0, 0, 0}, '{16'h4000, 0, 0, 0}, 16'h4400};
    vecs[3] = '{8'd1, 16'h3C00, '{16'h3C00, 0, 0, 0}, '{16'hC000, 0, 0, 0}, 16'hBC00};
    vecs[4] = '{8'd2, 16'h4000, '{16'h3800, 16'hBC00, 0, 0}, '{16'h4000, 16'h3C00, 0, 0}, 16'h4000};
    vecs[5] = '{8'd0, 16'h4200, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 16'h4200};
    vecs[6] = '{8'd4, 16'h0000, '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00}, '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00}, 16'h4400};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_count", 32'(out_count), 0);
    chk("rst_fmac_x", 32'(fmac_x), 0);
    chk("rst_state", 32'(dbg_state), 0);
    rst = 1'b0;
    @(negedge clk);

    // Table loop.
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 4; i++) begin
        job_x[i] = vecs[v].x[i];
        job_y[i] = vecs[v].y[i];
      end
      start_job(vecs[v].l, vecs[v].z);
      feed_pairs(int'(vecs[v].l), 0);
      get_result(0, d, c);
      chk($sformatf("vec%0d_data", v), 32'(d), 32'(vecs[v].exp_d));
      chk($sformatf("vec%0d_count", v), 32'(c), 32'(vecs[v].l));
    end

    // In_ready pattern with in_valid held high, and DONE latency.
    start_job(8'd2, 16'h0000);
    in_valid = 1'b1; in_x = 16'h3C00; in_y = 16'h4000;
    chk("pat_rdy0", 32'(in_ready), 1);
    @(negedge clk);
    in_x = 16'h4000; in_y = 16'h4200;
    chk("pat_rdy1", 32'(in_ready), 0);
    @(negedge clk);
    chk("pat_rdy2", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pat_rdy3", 32'(in_ready), 0);
    chk("pat_not_done_yet", 32'(out_valid), 0);
    @(negedge clk);
    chk("pat_out_valid", 32'(out_valid), 1);
    chk("pat_out_data", 32'(out_data), 32'h4800);
    chk("pat_out_count", 32'(out_count), 2);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Len 0 goes straight to DONE.
    start_job(8'd0, 16'h4200);
    chk("len0_valid", 32'(out_valid), 1);
    chk("len0_data", 32'(out_data), 32'h4200);
    chk("len0_count", 32'(out_count), 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("len0_idle", 32'(busy), 0);

    // FETCH stall: in_valid low for 5 cycles, nothing consumed.
    start_job(8'd3, 16'h3C00);
    for (int i = 0; i < 3; i++) begin
      repeat (5) @(negedge clk);
      chk($sformatf("stall_rdy%0d", i), 32'(in_ready), 1);
      chk($sformatf("stall_cnt%0d", i), 32'(out_count), 32'(i));
      in_valid = 1'b1; in_x = 16'h3C00; in_y = 16'h3C00;
      @(negedge clk);
      in_valid = 1'b0;
    end
    get_result(0, d, c);
    chk("stall_data", 32'(d), 32'h4400);

    // DONE hold with out_ready low; start pulses ignored.
    job_x[0] = 16'h3C00; job_y[0] = 16'h3C00;
    start_job(8'd1, 16'h0000);
    feed_pairs(1, 0);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      start = i[0]; len = 8'd2; z_init = 16'h4000;
      chk($sformatf("hold_valid%0d", i), 32'(out_valid), 1);
      chk($sformatf("hold_data%0d", i), 32'(out_data), 32'h3C00);
      chk($sformatf("hold_count%0d", i), 32'(out_count), 1);
      @(negedge clk);
    end
    start = 1'b0;
    get_result(0, d, c);
    chk("hold_final", 32'(d), 32'h3C00);

    // Abort in ACC of a len=4 job, then a fresh job.
    start_job(8'd4, 16'h0000);
    in_valid = 1'b1; in_x = 16'h3C00; in_y = 16'h3C00;
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort_in_acc", 32'(dbg_state), 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_rdy", 32'(in_ready), 0);
    chk("abort_cnt_hold", 32'(out_count), 0);
    job_x[0] = 16'h4000; job_y[0] = 16'h4000;
    start_job(8'd1, 16'h0000);
    feed_pairs(1, 0);
    get_result(0, d, c);
    chk("abort_recover", 32'(d), 32'h4400);

    // Async reset mid-FETCH.
    start_job(8'd3, 16'h3C00);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_rdy", 32'(in_ready), 0);
    chk("arst_data", 32'(out_data), 0);
    chk("arst_fmac_z", 32'(fmac_z), 0);
    chk("arst_valid", 32'(out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    job_x[0] = 16'h4000; job_y[0] = 16'h4200;
    job_x[1] = 16'h3C00; job_y[1] = 16'h3C00;
    start_job(8'd2, 16'h3C00);
    feed_pairs(2, 1);
    get_result(1, d, c);
    chk("arst_recover", 32'(d), 32'h4800);

    // Randomized jobs against the fold-of-fma model.
    for (int j = 0; j < 25; j++) begin
      logic [15:0] z;
      n = $urandom_range(1, 6);
      z = {1'($urandom), 5'($urandom_range(12, 17)), 10'($urandom)};
      acc = z;
      for (int i = 0; i < n; i++) begin
        job_x[i] = {1'($urandom), 5'($urandom_range(12, 17)), 10'($urandom)};
        job_y[i] = {1'($urandom), 5'($urandom_range(12, 17)), 10'($urandom)};
        acc = fma16(job_x[i], job_y[i], acc);
      end
      exp_q.push_back(acc);
      cnt_q.push_back(LEN_W'(n));
      start_job(LEN_W'(n), z);
      feed_pairs(n, 3);
      get_result(3, d, c);
      chk($sformatf("rnd%0d_data", j), 32'(d), 32'(exp_q.pop_front()));
      chk($sformatf("rnd%0d_count", j), 32'(c), 32'(cnt_q.pop_front()));
    end

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
